// File: rtl/pipelined_muxnto1.sv
// pipelined_muxnto1: N-input, W-bit multiplexer with one registered output
// stage and valid/ready handshaking on every input and on the output.
//
// Optional feature macro: PIPELINED_MUXNTO1_RR_EN
//   defined   -> round-robin mode (Mode=1) and the Ptr register are built.
//   undefined -> Mode is ignored; the block always runs in fixed-select mode.
//
// Handshake semantics (all channels, input and output):
//   A word moves across an interface on a rising edge where valid && ready
//   are both high. The output register can accept a new word when it is
//   empty or is being drained in the same cycle
//   (load_en = !OutValid || OutReady).
//   At most one InReady bit is high, and only for the granted channel. In
//   round-robin mode InReady depends on InValid, so producers must not make
//   InValid depend on InReady. A held output word (OutValid && !OutReady)
//   never changes. While Reset is high no InReady bit is raised.
module pipelined_muxnto1 #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] InData,
  input  logic [NUM_INPUTS-1:0]       InValid,
  output logic [NUM_INPUTS-1:0]       InReady,
  input  logic [SEL_WIDTH-1:0]        Select,
  input  logic                        Mode,
  output logic [WIDTH-1:0]            Out,
  output logic [SEL_WIDTH-1:0]        OutSel,
  output logic                        OutValid,
  input  logic                        OutReady
);

  // Index of the highest channel; the round-robin pointer wraps to 0 past it.
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

  // Output stage registers
  logic [WIDTH-1:0]     out_q,       out_d;
  logic [SEL_WIDTH-1:0] out_sel_q,   out_sel_d;
  logic                 out_valid_q, out_valid_d;

  // Handshake / grant signals
  logic                 load_en;
  logic                 xfer;
  logic                 grant_found;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 fixed_found;

  // The stage can take a new word when empty or when it is being drained now.
  assign load_en = !out_valid_q || OutReady;

  // Fixed-select grant: only a Select value that names a real channel grants.
  always_comb begin
    fixed_found = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (Select == SEL_WIDTH'(i)) begin
        fixed_found = 1'b1;
      end
    end
  end

`ifdef PIPELINED_MUXNTO1_RR_EN
  // Round-robin pointer: the channel given first priority in the next search.
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic                 rr_found;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic [SEL_WIDTH:0]   cand;

  // Round-robin search: first valid channel at or above ptr_q, wrapping to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, ptr_q} + (SEL_WIDTH + 1)'(k);
      if (cand >= (SEL_WIDTH + 1)'(NUM_INPUTS)) begin
        cand = cand - (SEL_WIDTH + 1)'(NUM_INPUTS);
      end
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (!rr_found && InValid[i] && (cand == (SEL_WIDTH + 1)'(i))) begin
          rr_found = 1'b1;
          rr_idx   = SEL_WIDTH'(i);
        end
      end
    end
  end

  // Grant source: Mode picks between the fixed select and the round-robin search.
  always_comb begin
    grant_found = fixed_found;
    grant_idx   = Select;
    if (Mode) begin
      grant_found = rr_found;
      grant_idx   = rr_idx;
    end
  end

  // Pointer advances past the granted channel only on round-robin transfers,
  // so it survives excursions into fixed mode untouched.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && Mode) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Mode has no effect in this build; the sink keeps it visibly consumed.
  logic unused_mode;
  assign unused_mode = Mode;

  // Grant source: fixed select only.
  always_comb begin
    grant_found = fixed_found;
    grant_idx   = Select;
  end
`endif

  // Ready fan-out: only the granted channel sees ready, and never during reset.
  always_comb begin
    InReady = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      InReady[i] = !Reset && load_en && grant_found &&
                   (grant_idx == SEL_WIDTH'(i));
    end
  end

  // A transfer happens when the granted channel also has valid data.
  assign xfer = |(InReady & InValid);

  // Output stage next state: load on transfer, drop valid on a bare drain,
  // otherwise hold (covers backpressure).
  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (InReady[i] && InValid[i]) begin
          out_d     = InData[i*WIDTH +: WIDTH];
          out_sel_d = SEL_WIDTH'(i);
        end
      end
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage registers; reset discards any held word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_q       <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Out      = out_q;
  assign OutSel   = out_sel_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_pipelined_muxnto1.sv
// Testbench for pipelined_muxnto1: a 4-input and a 3-input instance share one
// stimulus stream and are checked against a cycle model plus a word queue.
`timescale 1ns/1ps
module tb_pipelined_muxnto1;
  localparam int W = 32;
`ifdef PIPELINED_MUXNTO1_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [1:0]     select;
  logic           mode;
  logic           out_ready;

  logic [3:0]   in_ready4;
  logic [W-1:0] out4;
  logic [1:0]   out_sel4;
  logic         out_valid4;

  logic [2:0]   in_ready3;
  logic [W-1:0] out3;
  logic [1:0]   out_sel3;
  logic         out_valid3;

  pipelined_muxnto1 #(.WIDTH(W), .NUM_INPUTS(4), .SEL_WIDTH(2)) dut4 (
    .Clk(clk), .Reset(reset), .InData(in_data), .InValid(in_valid),
    .InReady(in_ready4), .Select(select), .Mode(mode), .Out(out4),
    .OutSel(out_sel4), .OutValid(out_valid4), .OutReady(out_ready)
  );

  pipelined_muxnto1 #(.WIDTH(W), .NUM_INPUTS(3), .SEL_WIDTH(2)) dut3 (
    .Clk(clk), .Reset(reset), .InData(in_data[3*W-1:0]), .InValid(in_valid[2:0]),
    .InReady(in_ready3), .Select(select), .Mode(mode), .Out(out3),
    .OutSel(out_sel3), .OutValid(out_valid3), .OutReady(out_ready)
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  bit           m_valid[2];
  logic [W-1:0] m_out[2];
  int           m_sel[2];
  int           m_ptr[2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int           force_ch = -1;
  logic [W-1:0] force_val = '0;
  logic [3:0]   last_ready4;
  logic [2:0]   last_ready3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // Expected ready vector from the rules: grant is Select (fixed) or the first
  // valid channel counting up from the pointer modulo N (round-robin).
  function automatic logic [15:0] exp_ready(input int d);
    int n;
    int c;
    logic le;
    n = n_of(d);
    if (reset) return 16'h0;
    le = !m_valid[d] || out_ready;
    if (!le) return 16'h0;
    if (RR_ON && mode) begin
      for (int k = 0; k < n; k++) begin
        c = (m_ptr[d] + k) % n;
        if (in_valid[c]) return 16'(1) << c;
      end
      return 16'h0;
    end
    if (int'(select) < n) return 16'(1) << select;
    return 16'h0;
  endfunction

  // Before the edge: check ready, retire the consumed word, advance the model.
  task automatic pre_edge(input int d);
    logic [15:0] er;
    logic [15:0] got_r;
    int          n;
    int          ch;
    logic [W-1:0] w;
    n     = n_of(d);
    er    = exp_ready(d);
    got_r = (d == 0) ? 16'(in_ready4) : 16'(in_ready3);
    check((d == 0) ? "in_ready4" : "in_ready3", got_r, er);
    if (!reset && m_valid[d] && out_ready) begin
      if (d == 0) begin
        check("sb_depth4", exp_q0.size(), 1);
        if (exp_q0.size() > 0) check("sb_word4", out4, exp_q0.pop_front());
      end else begin
        check("sb_depth3", exp_q1.size(), 1);
        if (exp_q1.size() > 0) check("sb_word3", out3, exp_q1.pop_front());
      end
    end
    if (reset) begin
      m_valid[d] = 1'b0;
      m_out[d]   = '0;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      ch = -1;
      for (int c = 0; c < n; c++) if (er[c] && in_valid[c]) ch = c;
      if (ch >= 0) begin
        w          = in_data[ch*W +: W];
        m_out[d]   = w;
        m_sel[d]   = ch;
        m_valid[d] = 1'b1;
        if (d == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
        if (RR_ON && mode) m_ptr[d] = (ch + 1) % n;
      end else if (m_valid[d] && out_ready) begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  // After the edge: registered outputs must match the model.
  task automatic post_edge(input int d);
    if (d == 0) begin
      check("out4", out4, m_out[0]);
      check("out_sel4", out_sel4, m_sel[0]);
      check("out_valid4", out_valid4, m_valid[0]);
    end else begin
      check("out3", out3, m_out[1]);
      check("out_sel3", out_sel3, m_sel[1]);
      check("out_valid3", out_valid3, m_valid[1]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic o);
    @(negedge clk);
    reset     = r;
    mode      = m;
    select    = s;
    in_valid  = v;
    out_ready = o;
    for (int c = 0; c < 4; c++) in_data[c*W +: W] = $urandom();
    if (force_ch >= 0) in_data[force_ch*W +: W] = force_val;
    #1;
    last_ready4 = in_ready4;
    last_ready3 = in_ready3;
    pre_edge(0);
    pre_edge(1);
    @(posedge clk);
    #1;
    post_edge(0);
    post_edge(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    logic [1:0]   seq[6];
    reset = 1'b1; mode = 1'b0; select = '0; in_valid = '0; out_ready = 1'b1;
    in_data = '0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_out[d] = '0; m_sel[d] = 0; m_ptr[d] = 0;
    end

    // Reset state
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
    cyc(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
    check("rst_ready", last_ready4, 4'b0000);
    check("rst_out", out4, 32'h0);
    check("rst_valid", out_valid4, 1'b0);

    // Fixed mode, channel 2
    force_ch = 2; force_val = 32'hDEADBEEF;
    cyc(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
    force_ch = -1;
    check("fix_ready", last_ready4, 4'b0100);
    check("fix_out", out4, 32'hDEADBEEF);
    check("fix_sel", out_sel4, 2'd2);
    check("fix_valid", out_valid4, 1'b1);

    // Backpressure: held word stays, no grants, then drain+fill without bubble
    held = out4;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 2'd1, 4'b0010, 1'b0);
      check("bp_ready", last_ready4, 4'b0000);
      check("bp_hold", out4, held);
    end
    cyc(1'b0, 1'b0, 2'd1, 4'b0010, 1'b1);
    check("bp_release_ready", last_ready4, 4'b0010);
    check("bp_release_sel", out_sel4, 2'd1);
    check("bp_release_valid", out_valid4, 1'b1);

    // Out-of-range select on the 3-input instance
    cyc(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1);
    check("oor_ready", last_ready3, 3'b000);
    cyc(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1);
    check("oor_ready2", last_ready3, 3'b000);
    check("oor_valid", out_valid3, 1'b0);

    // Reset while a word is held
    check("pre_rst_valid", out_valid4, 1'b1);
    cyc(1'b1, 1'b0, 2'd3, 4'b1111, 1'b1);
    check("mid_rst_out", out4, 32'h0);
    check("mid_rst_sel", out_sel4, 2'd0);
    check("mid_rst_valid", out_valid4, 1'b0);

`ifdef PIPELINED_MUXNTO1_RR_EN
    // Round-robin with all channels valid: 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
      seq[i] = out_sel4;
    end
    for (int i = 0; i < 6; i++) check("rr_seq", seq[i], 2'(i % 4));
    // Pointer now 2; one grant of channel 0 moves it to 1
    cyc(1'b0, 1'b1, 2'd0, 4'b0001, 1'b1);
    check("rr_ptr_set", out_sel4, 2'd0);
    // Skipping with channels 0 and 3 valid: 3, 0, 3
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 2'd0, 4'b1001, 1'b1);
      seq[i] = out_sel4;
    end
    check("rr_skip0", seq[0], 2'd3);
    check("rr_skip1", seq[1], 2'd0);
    check("rr_skip2", seq[2], 2'd3);
`else
    // Mode is ignored: only channel 1 may ever be granted
    seq[0] = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 2'd1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check("norr_ready", last_ready4 & 4'b1101, 4'b0000);
      if (out_valid4) check("norr_sel", out_sel4, 2'd1);
    end
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
